// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (F stage)
// and load/store traffic (M stage). One access is in flight at a time. Data accesses
// win over fetch because they belong to the older instruction. Returned words are
// latched, and the whole pipeline stalls until every wanted access of the current
// cycle has completed.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   InstrReqF, PCF             fetch request and address
//   MemReqM, MemWriteM         M-stage access request, 1 = store
//   ALUOutM, WriteDataM        data address and store data
//   InstrF, ReadDataM          latched instruction and load data
//   StallF/D/E/M, FlushW       pipeline hold signals and write-back bubble
//   MemReq, MemWe, MemAddr,
//   MemWData, MemRData,
//   MemReady                   memory-side handshake
//   BusErr                     sticky flag, set when an access times out
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InstrReqF,
  input  logic [31:0] PCF,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] InstrF,
  output logic [31:0] ReadDataM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushW,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        BusErr
);

  typedef enum logic [1:0] {StIdle, StData, StFetch} state_e;

  // Last counter value before an unanswered access is forced to complete.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        idone_q, idone_d;
  logic        ddone_q, ddone_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] wait_q, wait_d;
  logic        bus_err_q, bus_err_d;

  logic        instr_ok, data_ok, advance;
  logic        timed_out, done;
  logic [31:0] resp_data;

  assign instr_ok = idone_q | ~InstrReqF;
  assign data_ok  = ddone_q | ~MemReqM;
  assign advance  = instr_ok & data_ok;

  // A late MemReady on the final wait cycle still counts as a normal completion.
  assign timed_out = (wait_q == WaitLast) & ~MemReady;
  assign done      = MemReady | timed_out;
  assign resp_data = MemReady ? MemRData : 32'h0;

  always_comb begin
    state_d   = state_q;
    idone_d   = idone_q;
    ddone_d   = ddone_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    MemAddr   = 32'h0;
    MemWData  = 32'h0;

    case (state_q)
      StIdle: begin
        // Counter restarts for whichever access is launched next.
        wait_d = 16'h0;
        if (advance) begin
          idone_d = 1'b0;
          ddone_d = 1'b0;
        end else if (MemReqM && !ddone_q) begin
          state_d = StData;
        end else if (InstrReqF && !idone_q) begin
          state_d = StFetch;
        end
      end

      StData: begin
        MemReq   = 1'b1;
        MemWe    = MemWriteM;
        MemAddr  = ALUOutM;
        MemWData = WriteDataM;
        if (done) begin
          ddone_d   = 1'b1;
          bus_err_d = bus_err_q | timed_out;
          if (!MemWriteM) rdata_d = resp_data;
          wait_d    = 16'h0;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      StFetch: begin
        MemReq  = 1'b1;
        MemAddr = PCF;
        if (done) begin
          idone_d   = 1'b1;
          bus_err_d = bus_err_q | timed_out;
          instr_d   = resp_data;
          wait_d    = 16'h0;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idone_q   <= 1'b0;
      ddone_q   <= 1'b0;
      instr_q   <= 32'h0;
      rdata_q   <= 32'h0;
      wait_q    <= 16'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idone_q   <= idone_d;
      ddone_q   <= ddone_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign InstrF    = instr_q;
  assign ReadDataM = rdata_q;
  assign BusErr    = bus_err_q;

  // FlushW keeps a held M-stage instruction from committing twice.
  assign StallF = ~advance;
  assign StallD = ~advance;
  assign StallE = ~advance;
  assign StallM = ~advance;
  assign FlushW = ~advance;

endmodule
